// File: rtl/cci_mpf_shim_dbg_playback.sv
// Debug playback buffer: host fills a RAM over MMIO, then replays entries on a valid/ready stream.
// Latency: start write at cycle T presents entry 0 at T+4; one entry per cycle thereafter.
// Backpressure: out_ready low holds out_data/out_valid; reads are credit-limited by a 4-entry output FIFO.
module cci_mpf_shim_dbg_playback #(
  parameter int MMIO_BASE_ADDR  = 'h3000,
  parameter int N_MMIO_REG_BITS = 32,
  parameter int N_ENTRIES       = 1024,
  parameter int N_DATA_BITS     = 32,
  parameter int LOOP_MODE       = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mmio_wr_valid,
  input  logic [15:0]            mmio_wr_addr,
  input  logic [63:0]            mmio_wr_data,
  output logic                   out_valid,
  output logic [N_DATA_BITS-1:0] out_data,
  input  logic                   out_ready,
  output logic                   status_busy,
  output logic                   status_done,
  output logic                   status_err
);

  localparam int IW      = $clog2(N_ENTRIES);
  localparam int CW      = IW + 1;
  localparam int START_A = MMIO_BASE_ADDR >> 2;
  localparam int END_A   = (MMIO_BASE_ADDR + N_ENTRIES * N_MMIO_REG_BITS / 8) >> 2;
  localparam int CTRL_A  = END_A;
  localparam int ESHIFT  = N_MMIO_REG_BITS / 64;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DRAIN} state_t;

  // MMIO input registers
  logic        mmio_vld_q;
  logic [15:0] mmio_addr_q;
  logic [63:0] mmio_data_q;

  // Control state
  state_t          state_q, state_d;
  logic [IW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // Read pipeline and output FIFO
  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
  logic [N_DATA_BITS-1:0] rd_q1, rd_q2;
  logic                   v1_q, v2_q;
  logic [N_DATA_BITS-1:0] fifo_mem [4];
  logic [1:0]             fifo_wp_q, fifo_rp_q;
  logic [2:0]             fifo_cnt_q;

  // Decode / control combinational signals
  logic [31:0]   addr32, off32;
  logic          is_buf, is_ctrl, ctl_abort, ctl_start, start_go;
  logic [IW-1:0] buf_idx, cur_ptr, rd_addr;
  logic [CW-1:0] cnt_clamp, cur_cnt;
  logic          buf_we, rd_issue, flush, credit_ok, push, pop;
  logic          unused_bits;

  // Capture host writes once before decode
  always_ff @(posedge clk) begin
    if (!reset_n) mmio_vld_q <= 1'b0;
    else          mmio_vld_q <= mmio_wr_valid;
  end

  // Address/data side of the MMIO capture needs no reset
  always_ff @(posedge clk) begin
    mmio_addr_q <= mmio_wr_addr;
    mmio_data_q <= mmio_wr_data;
  end

  // Decode the registered MMIO write into buffer / control actions
  always_comb begin
    addr32    = {16'h0, mmio_addr_q};
    off32     = addr32 - 32'(START_A);
    is_buf    = mmio_vld_q && (addr32 >= 32'(START_A)) && (addr32 < 32'(END_A));
    is_ctrl   = mmio_vld_q && (addr32 == 32'(CTRL_A));
    buf_idx   = IW'(off32 >> ESHIFT);
    cnt_clamp = ({16'h0, mmio_data_q[31:16]} > 32'(N_ENTRIES)) ? CW'(N_ENTRIES)
                                                               : CW'(mmio_data_q[31:16]);
    ctl_abort = is_ctrl && mmio_data_q[1];
    ctl_start = is_ctrl && mmio_data_q[0] && !mmio_data_q[1] && (cnt_clamp != '0);
    credit_ok = ({1'b0, fifo_cnt_q} + {3'b0, v1_q} + {3'b0, v2_q}) < 4'd4;
  end

  // Only a subset of the data word and address offset is meaningful for a given config
  assign unused_bits = ^{mmio_data_q, off32};

  // FSM next state, read issue and sticky status
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    done_d   = done_q;
    err_d    = err_q;
    buf_we   = 1'b0;
    rd_issue = 1'b0;
    flush    = 1'b0;
    start_go = ctl_start && (state_q == S_IDLE);
    cur_ptr  = start_go ? '0 : rd_ptr_q;
    cur_cnt  = start_go ? cnt_clamp : count_q;
    rd_addr  = cur_ptr;
    if (ctl_abort) begin
      state_d = S_IDLE;
      flush   = 1'b1;
    end else begin
      if (is_buf) begin
        if (state_q == S_IDLE) buf_we = 1'b1;
        else                   err_d  = 1'b1;
      end
      if (start_go) begin
        state_d  = S_PLAY;
        count_d  = cnt_clamp;
        done_d   = 1'b0;
        rd_ptr_d = '0;
      end
      // The first read goes out in the start cycle itself to meet the T+4 latency
      if ((start_go || state_q == S_PLAY) && credit_ok) begin
        rd_issue = 1'b1;
        if ((CW'(cur_ptr) + CW'(1)) == cur_cnt) begin
          rd_ptr_d = '0;
          if (LOOP_MODE == 0) state_d = S_DRAIN;
        end else begin
          rd_ptr_d = cur_ptr + IW'(1);
        end
      end
      if (state_q == S_DRAIN && fifo_cnt_q == 3'd0 && !v1_q && !v2_q) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // FSM and status registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Playback RAM: two registered stages give the 2-cycle read latency; contents survive reset
  always_ff @(posedge clk) begin
    if (buf_we) mem[buf_idx] <= mmio_data_q[N_DATA_BITS-1:0];
    rd_q1 <= mem[rd_addr];
    rd_q2 <= rd_q1;
  end

  // Valid bits tracking reads in flight; abort drops them
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= rd_issue;
      v2_q <= v1_q;
    end
  end

  assign push        = v2_q && !flush;
  assign pop         = out_valid && out_ready;
  assign out_valid   = (fifo_cnt_q != 3'd0);
  assign out_data    = fifo_mem[fifo_rp_q];
  assign status_busy = (state_q != S_IDLE);
  assign status_done = done_q;
  assign status_err  = err_q;

  // Output FIFO pointers and occupancy; abort empties it
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      fifo_wp_q  <= 2'd0;
      fifo_rp_q  <= 2'd0;
      fifo_cnt_q <= 3'd0;
    end else begin
      if (push) fifo_wp_q <= fifo_wp_q + 2'd1;
      if (pop)  fifo_rp_q <= fifo_rp_q + 2'd1;
      fifo_cnt_q <= fifo_cnt_q + {2'b0, push} - {2'b0, pop};
    end
  end

  // Output FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wp_q] <= rd_q2;
  end

endmodule

// File: tb/tb_cci_mpf_shim_dbg_playback.sv
// Directed bench: one-shot instance (u0) and a loop-mode instance (u1) on a shared clock.
module tb_cci_mpf_shim_dbg_playback;

  localparam logic [15:0] A_BUF  = 16'h0C00;
  localparam logic [15:0] A_CTRL = 16'h1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        v0, v1;
  logic [15:0] maddr;
  logic [63:0] mdata;
  logic        ov0, ov1, rdy0, rdy1;
  logic [31:0] od0, od1;
  logic        busy0, done0, err0, busy1, done1, err1;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  cci_mpf_shim_dbg_playback u0 (
    .clk(clk), .reset_n(reset_n), .mmio_wr_valid(v0), .mmio_wr_addr(maddr),
    .mmio_wr_data(mdata), .out_valid(ov0), .out_data(od0), .out_ready(rdy0),
    .status_busy(busy0), .status_done(done0), .status_err(err0));

  cci_mpf_shim_dbg_playback #(.LOOP_MODE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .mmio_wr_valid(v1), .mmio_wr_addr(maddr),
    .mmio_wr_data(mdata), .out_valid(ov1), .out_data(od1), .out_ready(rdy1),
    .status_busy(busy1), .status_done(done1), .status_err(err1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the strobe is on the inputs for exactly one cycle
  task automatic wr(input bit which, input logic [15:0] a, input logic [63:0] d);
    maddr = a;
    mdata = d;
    if (which) v1 = 1'b1; else v0 = 1'b1;
    tick(1);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  logic [31:0] exp4 [4];
  logic [31:0] stall_dat [6];
  logic        stall_rdy [6];
  int          nvld;
  bit          busy_fell;

  initial begin
    exp4[0] = 32'h11; exp4[1] = 32'h22; exp4[2] = 32'h33; exp4[3] = 32'h44;
    stall_rdy[0] = 1'b1; stall_rdy[1] = 1'b0; stall_rdy[2] = 1'b0;
    stall_rdy[3] = 1'b1; stall_rdy[4] = 1'b1; stall_rdy[5] = 1'b1;
    stall_dat[0] = 32'h11; stall_dat[1] = 32'h22; stall_dat[2] = 32'h22;
    stall_dat[3] = 32'h22; stall_dat[4] = 32'h33; stall_dat[5] = 32'h44;

    reset_n = 1'b0; v0 = 1'b0; v1 = 1'b0; maddr = '0; mdata = '0;
    rdy0 = 1'b1; rdy1 = 1'b1;
    tick(3);
    chk("rst_valid", 64'(ov0), 64'd0);
    chk("rst_busy",  64'(busy0), 64'd0);
    chk("rst_done",  64'(done0), 64'd0);
    chk("rst_err",   64'(err0), 64'd0);
    chk("rst_valid_loop", 64'(ov1), 64'd0);
    reset_n = 1'b1;
    tick(1);

    // Basic playback of 4 entries with out_ready held high
    for (int i = 0; i < 4; i++) wr(0, A_BUF + 16'(i), 64'(exp4[i]));
    wr(0, A_CTRL, 64'h0004_0001);
    tick(2);
    chk("basic_T3_valid", 64'(ov0), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("basic_valid", 64'(ov0), 64'd1);
      chk("basic_data", 64'(od0), 64'(exp4[i]));
    end
    tick(1);
    chk("basic_T8_valid", 64'(ov0), 64'd0);
    tick(1);
    chk("basic_T9_done", 64'(done0), 64'd1);
    chk("basic_T9_busy", 64'(busy0), 64'd0);

    // Buffer write during PLAY is dropped and flagged; start clears done
    wr(0, A_CTRL, 64'h0004_0001);
    wr(0, A_BUF + 16'd1, 64'h99);
    chk("restart_done_clr", 64'(done0), 64'd0);
    chk("restart_busy", 64'(busy0), 64'd1);
    tick(1);
    chk("drop_err", 64'(err0), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("drop_data", 64'(od0), 64'(exp4[i]));
    end
    tick(2);
    chk("drop_done", 64'(done0), 64'd1);

    // Stall pattern 1,0,0,1: replay also shows entry 1 was not overwritten
    wr(0, A_CTRL, 64'h0004_0001);
    tick(2);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      rdy0 = stall_rdy[i];
      chk("stall_valid", 64'(ov0), 64'd1);
      chk("stall_data", 64'(od0), 64'(stall_dat[i]));
    end
    tick(1);
    rdy0 = 1'b1;
    chk("stall_end_valid", 64'(ov0), 64'd0);
    tick(2);
    chk("stall_done", 64'(done0), 64'd1);

    // Count 0xFFFF clamps to the buffer depth
    wr(0, A_CTRL, 64'hFFFF_0001);
    nvld = 0;
    busy_fell = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (ov0) nvld++;
      if (!busy0) begin
        busy_fell = 1'b1;
        break;
      end
    end
    chk("clamp_finished", 64'(busy_fell), 64'd1);
    chk("clamp_count", 64'(nvld), 64'd1024);
    chk("clamp_done", 64'(done0), 64'd1);

    // Count 0 is a no-op
    wr(0, A_CTRL, 64'h0000_0001);
    tick(1);
    chk("cnt0_busy_T2", 64'(busy0), 64'd0);
    tick(1);
    chk("cnt0_busy_T3", 64'(busy0), 64'd0);
    chk("cnt0_valid", 64'(ov0), 64'd0);
    chk("cnt0_done_kept", 64'(done0), 64'd1);

    // Reset at entry 2 of 4 aborts; restart replays preserved data
    wr(0, A_CTRL, 64'h0004_0001);
    tick(3);
    chk("rmid_e0", 64'(od0), 64'h11);
    tick(1);
    chk("rmid_e1", 64'(od0), 64'h22);
    tick(1);
    chk("rmid_e2", 64'(od0), 64'h33);
    reset_n = 1'b0;
    tick(1);
    chk("rmid_valid", 64'(ov0), 64'd0);
    chk("rmid_busy", 64'(busy0), 64'd0);
    chk("rmid_done", 64'(done0), 64'd0);
    chk("rmid_err", 64'(err0), 64'd0);
    reset_n = 1'b1;
    tick(1);
    wr(0, A_CTRL, 64'h0004_0001);
    tick(2);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("rmid_replay", 64'(od0), 64'(exp4[i]));
    end
    tick(3);

    // Loop mode: A,B,A,B... without bubbles, then abort
    wr(1, A_BUF, 64'hA);
    wr(1, A_BUF + 16'd1, 64'hB);
    wr(1, A_CTRL, 64'h0002_0001);
    tick(2);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("loop_valid", 64'(ov1), 64'd1);
      chk("loop_data", 64'(od1), (i % 2 == 0) ? 64'hA : 64'hB);
    end
    wr(1, A_CTRL, 64'h2);
    chk("abort_T1_valid", 64'(ov1), 64'd1);
    tick(1);
    chk("abort_valid", 64'(ov1), 64'd0);
    chk("abort_busy", 64'(busy1), 64'd0);
    chk("abort_done", 64'(done1), 64'd0);
    tick(3);
    chk("abort_stays_idle", 64'(ov1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
